ball_motion: RTL and testbench

Ball position and direction engine for the Pong datapath. Consumes the one-clock speed tick from the ball delay unit, moves the ball one pixel per axis per tick, and reflects it off the top and bottom walls and off both paddles. Flags misses as scoring events. Returns a one-clock `collision` pulse on every paddle hit to the delay unit, which uses it to shorten the tick period.

---
 rtl/ball_motion_if.sv | 25 ++
 rtl/ball_motion.sv | 162 ++++++++++++++++
 tb/tb_ball_motion.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ball_motion_if.sv
// rtl/ball_motion_if.sv - Pong ball engine control/status bundle
// master drives the tick/serve/paddle inputs, slave is the ball engine.
interface ball_motion_if;
   logic       tick;
   logic       serve;
   logic       serve_dir;
   logic [9:0] lpaddle_y;
   logic [9:0] rpaddle_y;
   logic [9:0] ball_x;
   logic [9:0] ball_y;
   logic       collision;
   logic       score_l;
   logic       score_r;
   logic       in_play;

   modport master (
      output tick, serve, serve_dir, lpaddle_y, rpaddle_y,
      input  ball_x, ball_y, collision, score_l, score_r, in_play
   );

   modport slave (
      input  tick, serve, serve_dir, lpaddle_y, rpaddle_y,
      output ball_x, ball_y, collision, score_l, score_r, in_play
   );
endinterface

// File: rtl/ball_motion.sv
// rtl/ball_motion.sv - Pong ball position/direction engine with wall and paddle reflection
// Optional BALL_AUTO_SERVE_EN: relaunch automatically toward the scorer after the hold.
module ball_motion #(
   parameter int H_RES          = 640,
   parameter int V_RES          = 480,
   parameter int BALL_SIZE      = 8,
   parameter int PADDLE_W       = 8,
   parameter int PADDLE_H       = 64,
   parameter int LEFT_PADDLE_X  = 16,
   parameter int RIGHT_PADDLE_X = 616,
   parameter int START_X        = 316,
   parameter int START_Y        = 236,
   parameter int HOLD_TICKS     = 64
) (
   input logic          clk,
   input logic          rst,
   ball_motion_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MOVE, SCORED} state_t;

   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
   localparam logic [9:0]  X0       = 10'(START_X);
   localparam logic [9:0]  Y0       = 10'(START_Y);
   localparam logic [10:0] BS11     = 11'(BALL_SIZE);
   localparam logic [10:0] PH11     = 11'(PADDLE_H);
   localparam logic [10:0] L_FACE   = 11'(LEFT_PADDLE_X + PADDLE_W);
   localparam logic [10:0] R_FACE   = 11'(RIGHT_PADDLE_X);
   localparam logic [10:0] X_MAX    = 11'(H_RES - BALL_SIZE);
   localparam logic [10:0] Y_MAX    = 11'(V_RES - BALL_SIZE);

   state_t        state, state_nxt;
   logic [9:0]    x_q, y_q, x_nxt, y_nxt;
   logic          dx_q, dy_q, dx_nxt, dy_nxt;   // dx 1 = right, dy 1 = down
   logic [HW-1:0] hold_q, hold_nxt;
   logic          coll_q, coll_nxt, scl_q, scl_nxt, scr_q, scr_nxt, play_q;
`ifdef BALL_AUTO_SERVE_EN
   logic          auto_q, auto_nxt, adir_q, adir_nxt;
`endif

   // Edge sums are 11 bits so paddle_y + PADDLE_H never wraps.
   logic [10:0] bx, by, lp, rp;
   logic        top_hit, bot_hit, l_hit, r_hit, l_miss, r_miss;
   assign bx      = {1'b0, x_q};
   assign by      = {1'b0, y_q};
   assign lp      = {1'b0, bus.lpaddle_y};
   assign rp      = {1'b0, bus.rpaddle_y};
   assign top_hit = (by == 11'd0) && !dy_q;
   assign bot_hit = (by == Y_MAX) && dy_q;
   assign l_hit   = !dx_q && (bx == L_FACE) && (by + BS11 > lp) && (by < lp + PH11);
   assign r_hit   = dx_q && (bx + BS11 == R_FACE) && (by + BS11 > rp) && (by < rp + PH11);
   assign l_miss  = (bx == 11'd0) && !dx_q;
   assign r_miss  = (bx == X_MAX) && dx_q;

   always_comb begin
      state_nxt = state;
      x_nxt     = x_q;
      y_nxt     = y_q;
      dx_nxt    = dx_q;
      dy_nxt    = dy_q;
      hold_nxt  = hold_q;
      coll_nxt  = 1'b0;
      scl_nxt   = 1'b0;
      scr_nxt   = 1'b0;
`ifdef BALL_AUTO_SERVE_EN
      auto_nxt  = auto_q;
      adir_nxt  = adir_q;
`endif
      case (state)
         IDLE: begin
            x_nxt = X0;
            y_nxt = Y0;
`ifdef BALL_AUTO_SERVE_EN
            if (auto_q || bus.serve) begin
               state_nxt = MOVE;
               dx_nxt    = auto_q ? adir_q : bus.serve_dir;
               dy_nxt    = 1'b0;
               auto_nxt  = 1'b0;
            end
`else
            if (bus.serve) begin
               state_nxt = MOVE;
               dx_nxt    = bus.serve_dir;
               dy_nxt    = 1'b0;
            end
`endif
         end
         MOVE: if (bus.tick) begin
            if (l_miss || r_miss) begin
               state_nxt = SCORED;
               hold_nxt  = '0;
               scr_nxt   = l_miss;
               scl_nxt   = r_miss;
`ifdef BALL_AUTO_SERVE_EN
               adir_nxt  = l_miss;
`endif
            end else begin
               dx_nxt   = l_hit ? 1'b1 : (r_hit ? 1'b0 : dx_q);
               dy_nxt   = top_hit ? 1'b1 : (bot_hit ? 1'b0 : dy_q);
               coll_nxt = l_hit || r_hit;
               x_nxt    = dx_nxt ? x_q + 10'd1 : x_q - 10'd1;
               y_nxt    = dy_nxt ? y_q + 10'd1 : y_q - 10'd1;
            end
         end
         SCORED: if (bus.tick) begin
            if (hold_q == HOLD_LAST) begin
               state_nxt = IDLE;
               hold_nxt  = '0;
               x_nxt     = X0;
               y_nxt     = Y0;
`ifdef BALL_AUTO_SERVE_EN
               auto_nxt  = 1'b1;
`endif
            end else begin
               hold_nxt = hold_q + HW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         x_q    <= X0;
         y_q    <= Y0;
         dx_q   <= 1'b1;
         dy_q   <= 1'b0;
         hold_q <= '0;
         coll_q <= 1'b0;
         scl_q  <= 1'b0;
         scr_q  <= 1'b0;
         play_q <= 1'b0;
`ifdef BALL_AUTO_SERVE_EN
         auto_q <= 1'b0;
         adir_q <= 1'b0;
`endif
      end else begin
         state  <= state_nxt;
         x_q    <= x_nxt;
         y_q    <= y_nxt;
         dx_q   <= dx_nxt;
         dy_q   <= dy_nxt;
         hold_q <= hold_nxt;
         coll_q <= coll_nxt;
         scl_q  <= scl_nxt;
         scr_q  <= scr_nxt;
         play_q <= (state_nxt == MOVE);
`ifdef BALL_AUTO_SERVE_EN
         auto_q <= auto_nxt;
         adir_q <= adir_nxt;
`endif
      end
   end

   assign bus.ball_x    = x_q;
   assign bus.ball_y    = y_q;
   assign bus.collision = coll_q;
   assign bus.score_l   = scl_q;
   assign bus.score_r   = scr_q;
   assign bus.in_play   = play_q;
endmodule

// File: tb/tb_ball_motion.sv
// tb/tb_ball_motion.sv - directed bench for ball_motion
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_ball_motion;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       track = 1'b0;
   logic [9:0] lp_val = 10'd0;
   logic [9:0] rp_val = 10'd0;
   int         checks = 0;
   int         errors = 0;
   int         coll_cnt = 0, scl_cnt = 0, scr_cnt = 0;
   int         c0, l0, r0;

   ball_motion_if bus();

   ball_motion dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Paddles can follow the ball so every paddle face becomes a bounce.
   assign bus.lpaddle_y = track ? bus.ball_y : lp_val;
   assign bus.rpaddle_y = track ? bus.ball_y : rp_val;

   always @(posedge clk) begin
      if (bus.collision) coll_cnt <= coll_cnt + 1;
      if (bus.score_l)   scl_cnt  <= scl_cnt + 1;
      if (bus.score_r)   scr_cnt  <= scr_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_pos(input string tag, input int x, input int y);
      check({tag, "_x"}, 32'(bus.ball_x), 32'(x));
      check({tag, "_y"}, 32'(bus.ball_y), 32'(y));
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic do_serve(input logic dir);
      bus.serve = 1'b1;
      bus.serve_dir = dir;
      bus.tick = 1'b1;
      @(negedge clk);
      bus.serve = 1'b0;
      bus.tick = 1'b0;
   endtask

   task automatic run_ticks(input int n);
      bus.tick = 1'b1;
      repeat (n) @(negedge clk);
      bus.tick = 1'b0;
   endtask

   task automatic snap();
      c0 = coll_cnt;
      l0 = scl_cnt;
      r0 = scr_cnt;
   endtask

   initial begin
      bus.tick = 1'b0;
      bus.serve = 1'b0;
      bus.serve_dir = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_x", 32'(bus.ball_x), 32'd316);
      check("rst_y", 32'(bus.ball_y), 32'd236);
      check("rst_in_play", 32'(bus.in_play), 32'd0);
      check("rst_collision", 32'(bus.collision), 32'd0);
      check("rst_scores", 32'({bus.score_l, bus.score_r}), 32'd0);
      rst = 1'b1;

      // Serve right; the tick coincident with serve is ignored.
      rp_val = 10'd400;
      snap();
      do_serve(1'b1);
      check("serve_in_play", 32'(bus.in_play), 32'd1);
      check_pos("serve_tick_ignored", 316, 236);
      run_ticks(3);
      check_pos("three_ticks", 319, 233);
      check("three_ticks_pulses", 32'((coll_cnt - c0) + (scl_cnt - l0) + (scr_cnt - r0)), 32'd0);

      // Top wall, then past a misplaced right paddle to a right miss.
      run_ticks(233);
      check_pos("at_top", 552, 0);
      run_ticks(1);
      check_pos("top_bounce", 553, 1);
      run_ticks(79);
      check_pos("at_right_edge", 632, 80);
      check("right_edge_in_play", 32'(bus.in_play), 32'd1);
      run_ticks(1);
      check_pos("right_miss_frozen", 632, 80);
      check("right_miss_score_l", 32'(bus.score_l), 32'd1);
      check("right_miss_in_play", 32'(bus.in_play), 32'd0);
      run_ticks(63);
      check_pos("hold_63", 632, 80);
      check("score_l_once", 32'(scl_cnt - l0), 32'd1);
      check("wall_no_collision", 32'(coll_cnt - c0), 32'd0);
      run_ticks(1);
      check_pos("hold_done_recentred", 316, 236);
      check("hold_done_in_play", 32'(bus.in_play), 32'd0);
`ifdef BALL_AUTO_SERVE_EN
      @(negedge clk);
      check("auto_serve_in_play", 32'(bus.in_play), 32'd1);
      run_ticks(1);
      check_pos("auto_serve_dir_left", 315, 235);
`else
      repeat (3) @(negedge clk);
      check("idle_waits_in_play", 32'(bus.in_play), 32'd0);
      run_ticks(2);
      check_pos("idle_ignores_ticks", 316, 236);
`endif

      // Left paddle hit: serve left, top bounce at x=80, reach (24,56).
      do_reset();
      lp_val = 10'd30;
      snap();
      do_serve(1'b0);
      run_ticks(292);
      check_pos("reach_left_face", 24, 56);
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
      check("lhit_collision", 32'(bus.collision), 32'd1);
      check_pos("lhit_bounce", 25, 57);
      @(negedge clk);
      check("lhit_collision_drops", 32'(bus.collision), 32'd0);
      check("lhit_count", 32'(coll_cnt - c0), 32'd1);

      // Left paddle out of reach: pass, miss at x=0, hold 64 ticks.
      do_reset();
      lp_val = 10'd300;
      snap();
      do_serve(1'b0);
      run_ticks(293);
      check_pos("lpass", 23, 57);
      check("lpass_no_collision", 32'(coll_cnt - c0), 32'd0);
      run_ticks(23);
      check_pos("at_left_edge", 0, 80);
      run_ticks(1);
      check_pos("left_miss_frozen", 0, 80);
      check("left_miss_score_r", 32'(bus.score_r), 32'd1);
      check("left_miss_in_play", 32'(bus.in_play), 32'd0);
      run_ticks(64);
      check_pos("left_hold_done", 316, 236);
      check("score_r_once", 32'(scr_cnt - r0), 32'd1);
      check("score_l_none", 32'(scl_cnt - l0), 32'd0);

      // Rally with tracking paddles: serve right reaches (24,0) up-left after 17228 ticks.
      do_reset();
      track = 1'b1;
      snap();
      do_serve(1'b1);
      run_ticks(17228);
      check_pos("corner_reach", 24, 0);
      check("rally_hits", 32'(coll_cnt - c0), 32'd29);
      track = 1'b0;
      lp_val = 10'd0;
      rp_val = 10'd0;
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
      check_pos("corner_bounce", 25, 1);
      check("corner_collision", 32'(bus.collision), 32'd1);
      @(negedge clk);
      check("corner_single_pulse", 32'(coll_cnt - c0), 32'd30);

      // Reset mid-move with a tick pending.
      do_reset();
      do_serve(1'b1);
      run_ticks(84);
      check_pos("mid_move", 400, 152);
      rst = 1'b0;
      bus.tick = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      bus.tick = 1'b0;
      check_pos("mid_reset", 316, 236);
      check("mid_reset_in_play", 32'(bus.in_play), 32'd0);
      run_ticks(2);
      check_pos("after_reset_idle", 316, 236);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
